afu_transpose_stream: RTL and testbench

//  Parametrised successor of the AFU-side 32x32 transpose path: accepts 512-bit cache lines, each one
//  row of an NxN tile (N = 512/DATA_WIDTH), and emits the tile transposed, one column per line.

---
 rtl/afu_pkg.sv | 18 +
 rtl/afu_transpose_stream_if.sv | 32 +++
 rtl/afu_transpose_stream_bank.sv | 44 ++++
 rtl/afu_transpose_stream.sv | 131 +++++++++++++
 tb/tb_afu_transpose_stream.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/afu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : afu_pkg
// Description : Shared constants and helpers for the AFU data-path blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package afu_pkg;

    // Every AFU stream moves whole 512-bit cache lines.
    localparam int LINE_WIDTH = 512;

    // Number of DATA_WIDTH-bit elements packed into one cache line.
    function automatic int elems_per_line(input int dw);
        return LINE_WIDTH / dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/afu_transpose_stream_if.sv
`default_nettype none
// ============================================================================
// Interface   : afu_transpose_stream_if
// Description : Cache-line stream between the read-response FIFO, the
//               transpose block and the write-request FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface afu_transpose_stream_if;
    import afu_pkg::*;

    logic [LINE_WIDTH-1:0] input_fifo_din;
    logic                  input_fifo_we;
    logic                  input_fifo_full;
    logic                  mode_transpose;
    logic [LINE_WIDTH-1:0] output_fifo_dout;
    logic                  output_fifo_re;
    logic                  output_fifo_empty;

    // Environment side: pushes rows, pops output lines.
    modport master (
        output input_fifo_din, input_fifo_we, mode_transpose, output_fifo_re,
        input  input_fifo_full, output_fifo_dout, output_fifo_empty
    );

    // Transpose block side.
    modport slave (
        input  input_fifo_din, input_fifo_we, mode_transpose, output_fifo_re,
        output input_fifo_full, output_fifo_dout, output_fifo_empty
    );

endinterface
`default_nettype wire

// File: rtl/afu_transpose_stream_bank.sv
`default_nettype none
// ============================================================================
// Module      : transpose_bank
// Description : One NxN element tile held in registers. Rows are written
//               whole; reads return either a stored row or a gathered column.
// Revision    : 1.0 - initial release
// ============================================================================
module transpose_bank
    import afu_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    localparam int c_n        = elems_per_line(DATA_WIDTH),
    localparam int c_idx_w    = $clog2(c_n)
) (
    input  wire logic                  clk,
    input  wire logic                  wr_en,
    input  wire logic [c_idx_w-1:0]    wr_row,
    input  wire logic [LINE_WIDTH-1:0] wr_line,
    input  wire logic [c_idx_w-1:0]    rd_idx,
    input  wire logic                  rd_mode,
    output logic      [LINE_WIDTH-1:0] rd_line
);

    logic [LINE_WIDTH-1:0] r_rows [c_n];

    // Row storage: pure data, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_rows[wr_row] <= wr_line;
        end
    end

    // Read mux: whole row in pass-through, element rd_idx of every row in transpose.
    always_comb begin
        rd_line = r_rows[rd_idx];
        if (rd_mode) begin
            for (int r = 0; r < c_n; r++) begin
                rd_line[r*DATA_WIDTH +: DATA_WIDTH] = r_rows[r][rd_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/afu_transpose_stream.sv
`default_nettype none
// ============================================================================
// Module      : afu_transpose_stream
// Description : Ping-pong tile transposer. Rows of an NxN tile fill one bank
//               while the other bank drains columns (or rows in pass-through)
//               into a first-word-fall-through output register.
// Revision    : 1.0 - initial release
// ============================================================================
module afu_transpose_stream
    import afu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    afu_transpose_stream_if.slave     bus,
    output logic      [CNT_WIDTH-1:0] block_count
);

    localparam int c_n     = elems_per_line(DATA_WIDTH);
    localparam int c_idx_w = $clog2(c_n);
    localparam logic [c_idx_w-1:0] c_last = c_idx_w'(c_n - 1);

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_dw
        $error("afu_transpose_stream: DATA_WIDTH must be 8, 16, 32 or 64");
    end

    logic                  r_wr_sel;
    logic                  r_rd_sel;
    logic [c_idx_w-1:0]    r_wr_row;
    logic [c_idx_w-1:0]    r_rd_col;
    logic [1:0]            r_bank_full;
    logic [1:0]            r_bank_mode;
    logic                  r_out_valid;
    logic [LINE_WIDTH-1:0] r_dout;
    logic [CNT_WIDTH-1:0]  r_block_count;

    logic                  w_accept;
    logic                  w_load;
    logic                  w_wr_last;
    logic                  w_rd_last;
    logic [LINE_WIDTH-1:0] w_bank_line [2];
    logic [LINE_WIDTH-1:0] w_rd_line;

    // Full only looks at registered flags, so a freed bank refills one cycle later.
    assign w_accept  = bus.input_fifo_we && !r_bank_full[r_wr_sel];
    assign w_load    = r_bank_full[r_rd_sel] && (!r_out_valid || bus.output_fifo_re);
    assign w_wr_last = (r_wr_row == c_last);
    assign w_rd_last = (r_rd_col == c_last);
    assign w_rd_line = w_bank_line[r_rd_sel];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        transpose_bank #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk     (clk),
            .wr_en   (w_accept && (r_wr_sel == 1'(b))),
            .wr_row  (r_wr_row),
            .wr_line (bus.input_fifo_din),
            .rd_idx  (r_rd_col),
            .rd_mode (r_bank_mode[b]),
            .rd_line (w_bank_line[b])
        );
    end

    // Write pointer: walk rows of the filling bank, capture the tile mode on row 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_sel    <= 1'b0;
            r_wr_row    <= '0;
            r_bank_mode <= '0;
        end else if (w_accept) begin
            if (r_wr_row == '0) begin
                r_bank_mode[r_wr_sel] <= bus.mode_transpose;
            end
            if (w_wr_last) begin
                r_wr_sel <= ~r_wr_sel;
                r_wr_row <= '0;
            end else begin
                r_wr_row <= r_wr_row + 1'b1;
            end
        end
    end

    // Bank occupancy: set by the last row written, cleared by the last line loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bank_full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_load && w_rd_last && (r_rd_sel == 1'(b))) begin
                    r_bank_full[b] <= 1'b0;
                end
                if (w_accept && w_wr_last && (r_wr_sel == 1'(b))) begin
                    r_bank_full[b] <= 1'b1;
                end
            end
        end
    end

    // Read side: load the next line into the output register whenever it is free or being popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_sel      <= 1'b0;
            r_rd_col      <= '0;
            r_out_valid   <= 1'b0;
            r_dout        <= '0;
            r_block_count <= '0;
        end else if (w_load) begin
            r_dout      <= w_rd_line;
            r_out_valid <= 1'b1;
            if (w_rd_last) begin
                r_rd_sel      <= ~r_rd_sel;
                r_rd_col      <= '0;
                r_block_count <= r_block_count + 1'b1;
            end else begin
                r_rd_col <= r_rd_col + 1'b1;
            end
        end else if (bus.output_fifo_re) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.input_fifo_full   = r_bank_full[r_wr_sel];
    assign bus.output_fifo_empty = ~r_out_valid;
    assign bus.output_fifo_dout  = r_dout;
    assign block_count           = r_block_count;

endmodule
`default_nettype wire

// File: tb/tb_afu_transpose_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_afu_transpose_stream
// Description : Directed bench for afu_transpose_stream at DATA_WIDTH
//               16 (main), 8, 32 and 64, one instance per width.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_afu_transpose_stream;
    import afu_pkg::*;

    localparam int c_ndut = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] din;
    logic         we;
    logic         mode;
    logic         re;
    int           sel;

    wire [c_ndut-1:0][511:0] dout_arr;
    wire [c_ndut-1:0]        empty_arr;
    wire [c_ndut-1:0]        full_arr;
    wire [c_ndut-1:0][31:0]  cnt_arr;

    int           tests = 0;
    int           fails = 0;
    logic [511:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_ndut; g++) begin : g_dut
        localparam int c_dw = (g == 0) ? 16 : (g == 1) ? 8 : (g == 2) ? 32 : 64;
        afu_transpose_stream_if u_if ();
        assign u_if.input_fifo_din = din;
        assign u_if.input_fifo_we  = we && (sel == g);
        assign u_if.mode_transpose = mode;
        assign u_if.output_fifo_re = re && (sel == g);
        assign dout_arr[g]         = u_if.output_fifo_dout;
        assign empty_arr[g]        = u_if.output_fifo_empty;
        assign full_arr[g]         = u_if.input_fifo_full;
        afu_transpose_stream #(
            .DATA_WIDTH (c_dw),
            .CNT_WIDTH  (32)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .bus         (u_if.slave),
            .block_count (cnt_arr[g])
        );
    end

    function automatic int dw_of(input int k);
        case (k)
            0:       return 16;
            1:       return 8;
            2:       return 32;
            default: return 64;
        endcase
    endfunction

    // Element e of line idx: transpose -> tile*37 + e*n + idx, pass/row -> tile*37 + idx*n + e.
    function automatic logic [511:0] line_of(input int dw, input int tile, input int idx, input bit tr);
        int           n;
        longint       v;
        logic [511:0] l;
        n = 512 / dw;
        for (int b = 0; b < 512; b++) begin
            int e = b / dw;
            int k = b % dw;
            v = tr ? longint'(tile*37 + e*n + idx) : longint'(tile*37 + idx*n + e);
            l[b] = v[k];
        end
        return l;
    endfunction

    task automatic chk_line(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Push nrows rows of a tile; mode is m0 before toggle_row and m1 from it on.
    task automatic push_rows(input int tile, input int nrows, input bit m0, input bit m1, input int toggle_row);
        int dw = dw_of(sel);
        int n  = 512 / dw;
        int guard;
        if (nrows == n) begin
            for (int c = 0; c < n; c++) exp_q.push_back(line_of(dw, tile, c, m0));
        end
        for (int r = 0; r < nrows; r++) begin
            din   = line_of(dw, tile, r, 1'b0);
            mode  = (r < toggle_row) ? m0 : m1;
            we    = 1'b1;
            guard = 0;
            while (full_arr[sel] && guard < 4000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 4000) begin
                tests++;
                fails++;
                $error("FAIL push_timeout: observed full stuck at row %0d expected space", r);
                we = 1'b0;
                return;
            end
            @(negedge clk);
        end
        we = 1'b0;
    endtask

    // Pop count lines, comparing each against the scoreboard; stall_pct adds random re gaps.
    task automatic pop_lines(input int count, input int stall_pct, output int bubbles);
        int got   = 0;
        int guard = 0;
        bit started = 1'b0;
        bit stall;
        bubbles = 0;
        while (got < count && guard < 4000) begin
            stall = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
            if (!empty_arr[sel] && !stall) begin
                re      = 1'b1;
                started = 1'b1;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL sb_underflow: observed %0h expected no line", dout_arr[sel]);
                end else begin
                    chk_line("out_line", dout_arr[sel], exp_q.pop_front());
                end
                got++;
            end else begin
                re = 1'b0;
                if (started && empty_arr[sel]) bubbles++;
            end
            @(negedge clk);
            guard++;
        end
        re = 1'b0;
        if (got < count) begin
            tests++;
            fails++;
            $error("FAIL pop_timeout: observed %0d lines expected %0d", got, count);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bub;
        int nn;
        din   = '0;
        we    = 1'b0;
        mode  = 1'b0;
        re    = 1'b0;
        sel   = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk_bit("rst_empty", empty_arr[0], 1'b1);
        chk_bit("rst_full", full_arr[0], 1'b0);
        chk_cnt("rst_count", cnt_arr[0], 32'd0);
        chk_line("rst_dout", dout_arr[0], '0);

        // Reset in the middle of a tile discards the partial rows.
        push_rows(0, 5, 1'b1, 1'b1, 9999);
        chk_bit("partial_empty", empty_arr[0], 1'b1);
        reset = 1'b1;
        #1;
        chk_bit("midrst_empty", empty_arr[0], 1'b1);
        chk_bit("midrst_full", full_arr[0], 1'b0);
        chk_cnt("midrst_count", cnt_arr[0], 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        push_rows(1, 32, 1'b1, 1'b1, 9999);
        pop_lines(32, 0, bub);
        chk_cnt("t1_count", cnt_arr[0], 32'd1);

        // Transpose with latency check: empty still high right after the last row, low one edge later.
        push_rows(2, 32, 1'b1, 1'b1, 9999);
        chk_bit("lat_empty_t", empty_arr[0], 1'b1);
        @(negedge clk);
        chk_bit("lat_empty_t1", empty_arr[0], 1'b0);
        chk_bit("lat_full", full_arr[0], 1'b0);
        pop_lines(32, 0, bub);
        chk_cnt("t2_count", cnt_arr[0], 32'd2);
        chk_bit("t2_empty", empty_arr[0], 1'b1);

        // Pass-through with mid-tile mode change, then a transposed tile.
        push_rows(3, 32, 1'b0, 1'b1, 7);
        push_rows(4, 32, 1'b1, 1'b1, 9999);
        pop_lines(64, 0, bub);
        chk_cnt("t3_count", cnt_arr[0], 32'd4);

        // Backpressure: both banks full, extra push ignored, full releases after tile 5 drains.
        push_rows(5, 32, 1'b1, 1'b1, 9999);
        push_rows(6, 32, 1'b1, 1'b1, 9999);
        chk_bit("bp_full", full_arr[0], 1'b1);
        din = '1;
        we  = 1'b1;
        repeat (3) @(negedge clk);
        chk_bit("bp_full_ignored", full_arr[0], 1'b1);
        we = 1'b0;
        chk_cnt("bp_count_hold", cnt_arr[0], 32'd4);
        pop_lines(1, 0, bub);
        chk_bit("bp_full_pop1", full_arr[0], 1'b1);
        pop_lines(29, 0, bub);
        chk_bit("bp_full_pop30", full_arr[0], 1'b1);
        pop_lines(1, 0, bub);
        chk_bit("bp_full_release", full_arr[0], 1'b0);
        chk_cnt("bp_count_load", cnt_arr[0], 32'd5);
        pop_lines(33, 0, bub);
        chk_cnt("bp_count_end", cnt_arr[0], 32'd6);

        // Streaming: four tiles with we and re held high.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        fork
            begin
                push_rows(7, 32, 1'b1, 1'b1, 9999);
                push_rows(8, 32, 1'b1, 1'b1, 9999);
                push_rows(9, 32, 1'b1, 1'b1, 9999);
                push_rows(10, 32, 1'b1, 1'b1, 9999);
            end
            pop_lines(128, 0, bub);
        join
        chk_cnt("stream_bubbles", 32'(bub), 32'd0);
        chk_cnt("stream_count", cnt_arr[0], 32'd4);

        // Width sweep with random read stalls.
        for (int k = 1; k < c_ndut; k++) begin
            sel = k;
            nn  = 512 / dw_of(k);
            fork
                begin
                    push_rows(20 + sel, nn, 1'b1, 1'b1, 9999);
                    push_rows(30 + sel, nn, 1'b0, 1'b0, 9999);
                end
                pop_lines(2 * nn, 30, bub);
            join
            chk_cnt("sweep_count", cnt_arr[sel], 32'd2);
            chk_bit("sweep_empty", empty_arr[sel], 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
